// File: rtl/linear_layer_start_srl_fifo.sv
// Start-token FIFO between the Linear_Layer scheduler and the PE_i4xi4 start port.
// Addressed shift-register storage: pushes shift in at slot 0, the read port is indexed by occupancy.
module linear_layer_start_srl_fifo #(
  parameter int DATA_WIDTH  = 1,
  parameter int ADDR_WIDTH  = 2,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  if_afull,
  output logic [ADDR_WIDTH:0]   if_count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MID   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  afull_q, afull_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic wr_en;
  logic rd_en;

  // Requests are gated by the registered flags, so a full FIFO refuses writes
  // even when a read is accepted in the same cycle (and vice versa when empty).
  assign wr_en = if_write & full_n_q;
  assign rd_en = if_read & empty_n_q;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[0] = if_din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    case (state_q)
      S_EMPTY: begin
        if (wr_en) begin
          count_d = count_q + CW'(1);
          state_d = (count_d == DEPTH_C) ? S_FULL : S_MID;
        end
      end
      S_MID: begin
        if (wr_en && !rd_en) begin
          count_d = count_q + CW'(1);
          addr_d  = addr_q + ADDR_WIDTH'(1);
          if (count_d == DEPTH_C) state_d = S_FULL;
        end else if (rd_en && !wr_en) begin
          count_d = count_q - CW'(1);
          if (count_d == '0) begin
            addr_d  = '0;
            state_d = S_EMPTY;
          end else begin
            addr_d = addr_q - ADDR_WIDTH'(1);
          end
        end
      end
      S_FULL: begin
        if (rd_en) begin
          count_d = count_q - CW'(1);
          if (count_d == '0) begin
            addr_d  = '0;
            state_d = S_EMPTY;
          end else begin
            addr_d  = addr_q - ADDR_WIDTH'(1);
            state_d = S_MID;
          end
        end
      end
      default: begin
        state_d = S_EMPTY;
        count_d = '0;
        addr_d  = '0;
      end
    endcase
    full_n_d  = (state_d != S_FULL);
    empty_n_d = (state_d != S_EMPTY);
    afull_d   = (count_d >= AFULL_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_EMPTY;
      count_q   <= '0;
      addr_q    <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
      afull_q   <= afull_d;
    end
  end

  assign if_dout    = mem_q[addr_q];
  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;
  assign if_afull   = afull_q;
  assign if_count   = count_q;

endmodule
